prv664_rob_ctrl_mp: RTL and testbench

Parametrised reorder-buffer control core for the prv664 pipeline. It tracks allocation, completion, exception status and in-order retirement for DEPTH entries. It accepts WB_PORTS writeback tags per cycle and retires up to COMMIT_W entries per cycle. It sits between decode/dispatch (allocation), the execute engines (writeback) and commit. Payload storage stays in external 1R1W SRAMs addressed by the entry index this block exports.

---
 rtl/prv664_rob_ctrl_mp.sv | 103 ++++++++++
 tb/tb_prv664_rob_ctrl_mp.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/prv664_rob_ctrl_mp.sv
// prv664_rob_ctrl_mp: reorder-buffer control with multi-port writeback and multi-lane in-order commit
module prv664_rob_ctrl_mp #(
    parameter int   DEPTH    = 128,
    parameter logic ROB_NUM  = 1'b0,
    parameter int   WB_PORTS = 2,
    parameter int   COMMIT_W = 2,
    parameter int   IDXW     = $clog2(DEPTH),
    parameter int   TAGW     = IDXW + 1
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       flush_i,
    input  logic                       alloc_valid_i,
    input  logic                       alloc_complete_i,
    output logic                       alloc_ready_o,
    output logic [TAGW-1:0]            alloc_itag_o,
    input  logic [WB_PORTS-1:0]        wb_valid_i,
    input  logic [WB_PORTS*TAGW-1:0]   wb_itag_i,
    input  logic [WB_PORTS-1:0]        wb_excp_i,
    output logic [COMMIT_W-1:0]        cm_valid_o,
    input  logic [COMMIT_W-1:0]        cm_ready_i,
    output logic [COMMIT_W*TAGW-1:0]   cm_itag_o,
    output logic [COMMIT_W-1:0]        cm_excp_o,
    output logic [IDXW:0]              count_o,
    output logic                       empty_o,
    output logic                       full_o
);
    logic [IDXW:0]      head, tail, r;
    logic [DEPTH-1:0]   valid, complete, excp;
    logic [DEPTH-1:0]   vld_n, cmp_n, exc_n;
    logic [COMMIT_W-1:0] ret;
    logic [IDXW-1:0]    lane_idx [COMMIT_W];
    logic               chain, go, alloc_fire;
    logic [TAGW-1:0]    tag;

    assign count_o       = tail - head;
    assign empty_o       = count_o == '0;
    assign full_o        = count_o[IDXW];
    assign alloc_ready_o = !full_o;
    assign alloc_itag_o  = {ROB_NUM, tail[IDXW-1:0]};
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

    // commit lanes: a lane is valid only behind a valid, non-excepting lane; retire the leading ready run
    always_comb begin
        cm_valid_o = '0;
        cm_excp_o  = '0;
        cm_itag_o  = '0;
        ret        = '0;
        r          = '0;
        chain      = 1'b1;
        go         = 1'b1;
        for (int k = 0; k < COMMIT_W; k++) begin
            lane_idx[k] = head[IDXW-1:0] + IDXW'(k);
            cm_itag_o[k*TAGW +: TAGW] = {ROB_NUM, lane_idx[k]};
            cm_excp_o[k] = excp[lane_idx[k]];
            chain = chain && (count_o > (IDXW+1)'(k)) && complete[lane_idx[k]];
            cm_valid_o[k] = chain;
            go = go && chain && cm_ready_i[k];
            ret[k] = go;
            r = r + (IDXW+1)'(go);
            chain = chain && !excp[lane_idx[k]];
        end
    end

    // next entry state: retire first, then writebacks merge into still-valid entries, then allocation overwrites tail
    always_comb begin
        vld_n = valid;
        cmp_n = complete;
        exc_n = excp;
        tag   = '0;
        for (int k = 0; k < COMMIT_W; k++)
            if (ret[k]) vld_n[lane_idx[k]] = 1'b0;
        for (int p = 0; p < WB_PORTS; p++) begin
            tag = wb_itag_i[p*TAGW +: TAGW];
            if (wb_valid_i[p] && tag[IDXW] == ROB_NUM && vld_n[tag[IDXW-1:0]]) begin
                cmp_n[tag[IDXW-1:0]] = 1'b1;
                exc_n[tag[IDXW-1:0]] = exc_n[tag[IDXW-1:0]] | wb_excp_i[p];
            end
        end
        if (alloc_fire) begin
            vld_n[tail[IDXW-1:0]] = 1'b1;
            cmp_n[tail[IDXW-1:0]] = alloc_complete_i;
            exc_n[tail[IDXW-1:0]] = 1'b0;
        end
    end

    // state register; flush behaves exactly like reset
    always_ff @(posedge clk_i) begin
        if (srst_i || flush_i) begin
            head     <= '0;
            tail     <= '0;
            valid    <= '0;
            complete <= '0;
            excp     <= '0;
        end else begin
            head     <= head + r;
            tail     <= tail + (IDXW+1)'(alloc_fire);
            valid    <= vld_n;
            complete <= cmp_n;
            excp     <= exc_n;
        end
    end
endmodule

// File: tb/tb_prv664_rob_ctrl_mp.sv
// tb_prv664_rob_ctrl_mp: directed-vector bench for the ROB control core (DEPTH=8, ROB_NUM=1, 2 WB ports, 2 commit lanes)
module tb_prv664_rob_ctrl_mp;
    logic       clk = 1'b0;
    logic       srst, flush, alloc_valid, alloc_complete, alloc_ready;
    logic [3:0] alloc_itag;
    logic [1:0] wb_valid, wb_excp, cm_valid, cm_ready, cm_excp;
    logic [7:0] wb_itag, cm_itag;
    logic [3:0] count;
    logic       empty, full;
    int         n_vec = 0;
    int         n_bad = 0;

    prv664_rob_ctrl_mp #(.DEPTH(8), .ROB_NUM(1'b1), .WB_PORTS(2), .COMMIT_W(2)) dut (
        .clk_i(clk), .srst_i(srst), .flush_i(flush),
        .alloc_valid_i(alloc_valid), .alloc_complete_i(alloc_complete),
        .alloc_ready_o(alloc_ready), .alloc_itag_o(alloc_itag),
        .wb_valid_i(wb_valid), .wb_itag_i(wb_itag), .wb_excp_i(wb_excp),
        .cm_valid_o(cm_valid), .cm_ready_i(cm_ready), .cm_itag_o(cm_itag), .cm_excp_o(cm_excp),
        .count_o(count), .empty_o(empty), .full_o(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset();
        srst = 1'b1;
        tick();
        srst = 1'b0;
    endtask

    task automatic alloc_n(input int n, input logic c);
        alloc_valid = 1'b1;
        alloc_complete = c;
        repeat (n) tick();
        alloc_valid = 1'b0;
        alloc_complete = 1'b0;
    endtask

    task automatic wb(input logic [1:0] v, input logic [3:0] t0, input logic [3:0] t1, input logic [1:0] e);
        wb_valid = v;
        wb_itag = {t1, t0};
        wb_excp = e;
        tick();
        wb_valid = '0;
        wb_itag = '0;
        wb_excp = '0;
    endtask

    initial begin
        srst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_complete = 1'b0;
        wb_valid = '0; wb_itag = '0; wb_excp = '0; cm_ready = '0;
        reset();
        chk("rst_itag", alloc_itag, 4'h8);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", alloc_ready, 1);
        chk("rst_cmv", cm_valid, 2'b00);
        chk("rst_cme", cm_excp, 2'b00);
        chk("rst_cmitag", cm_itag, 8'h98);

        alloc_n(8, 1'b0);
        chk("fill_full", full, 1);
        chk("fill_ready", alloc_ready, 0);
        chk("fill_count", count, 8);
        chk("fill_itag", alloc_itag, 4'h8);
        alloc_n(1, 1'b0);
        chk("ovf_count", count, 8);
        chk("ovf_itag", alloc_itag, 4'h8);
        wb(2'b01, 4'h8, 4'h0, 2'b00);
        chk("fill_cmv", cm_valid, 2'b01);
        cm_ready = 2'b01;
        tick();
        cm_ready = 2'b00;
        chk("ret1_count", count, 7);
        chk("ret1_full", full, 0);
        chk("ret1_ready", alloc_ready, 1);
        chk("ret1_itag", alloc_itag, 4'h8);
        chk("ret1_cmitag", cm_itag, 8'hA9);

        reset();
        alloc_n(4, 1'b0);
        wb(2'b01, 4'hB, 4'h0, 2'b00);
        chk("ooo_wb3", cm_valid, 2'b00);
        wb(2'b01, 4'hA, 4'h0, 2'b00);
        chk("ooo_wb2", cm_valid, 2'b00);
        wb(2'b01, 4'h9, 4'h0, 2'b00);
        chk("ooo_wb1", cm_valid, 2'b00);
        wb(2'b01, 4'h8, 4'h0, 2'b00);
        chk("ooo_wb0", cm_valid, 2'b11);
        chk("ooo_itag", cm_itag, 8'h98);
        cm_ready = 2'b11;
        tick();
        chk("ooo_head2_count", count, 2);
        chk("ooo_head2_itag", cm_itag, 8'hBA);
        chk("ooo_head2_cmv", cm_valid, 2'b11);
        tick();
        cm_ready = 2'b00;
        chk("ooo_empty", empty, 1);
        chk("ooo_empty_cmv", cm_valid, 2'b00);

        reset();
        alloc_n(2, 1'b0);
        wb(2'b11, 4'h8, 4'h9, 2'b01);
        chk("exc_cmv", cm_valid, 2'b01);
        chk("exc_cme", cm_excp, 2'b01);
        cm_ready = 2'b11;
        tick();
        cm_ready = 2'b00;
        chk("exc_count", count, 1);
        chk("exc_next_cmv", cm_valid, 2'b01);
        chk("exc_next_cme", cm_excp, 2'b00);
        chk("exc_next_itag", cm_itag, 8'hA9);

        reset();
        alloc_n(7, 1'b0);
        wb(2'b11, 4'hD, 4'hD, 2'b10);
        wb(2'b01, 4'h6, 4'h0, 2'b01);
        wb(2'b11, 4'h8, 4'h9, 2'b00);
        wb(2'b11, 4'hA, 4'hB, 2'b00);
        wb(2'b01, 4'hC, 4'h0, 2'b00);
        cm_ready = 2'b11;
        tick();
        tick();
        chk("dual_count", count, 3);
        chk("dual_cmv", cm_valid, 2'b11);
        chk("dual_cme", cm_excp, 2'b10);
        tick();
        chk("foreign_count", count, 1);
        chk("foreign_cmv", cm_valid, 2'b00);
        chk("foreign_cme", cm_excp, 2'b00);
        cm_ready = 2'b00;

        reset();
        alloc_n(5, 1'b0);
        chk("pre_flush_count", count, 5);
        flush = 1'b1;
        alloc_valid = 1'b1;
        alloc_complete = 1'b1;
        wb(2'b01, 4'h8, 4'h0, 2'b00);
        flush = 1'b0;
        alloc_valid = 1'b0;
        alloc_complete = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_itag", alloc_itag, 4'h8);
        chk("flush_cmv", cm_valid, 2'b00);
        alloc_n(1, 1'b0);
        chk("post_flush_count", count, 1);
        chk("post_flush_cmv", cm_valid, 2'b00);

        reset();
        alloc_n(1, 1'b1);
        chk("cmpl_alloc_cmv", cm_valid, 2'b01);
        chk("cmpl_alloc_itag", cm_itag, 8'h98);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
